// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encodings, default parameters and helpers.
// Used by the transmitter and intended for reuse by the receive path.
package uart_tx_pkg;

    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DEF_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Bits needed to hold values 0..value-1 (at least 1).
    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

    // Even-parity bit of a payload (narrower payloads are zero-extended).
    function automatic logic even_parity(input logic [8:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Request/status handshake between the host logic and the UART transmitter.
interface uart_tx_if
    import uart_tx_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS
) ();

    logic                 i_tx_start;
    logic [DATA_BITS-1:0] i_tx_data;
    logic                 o_tx_busy;
    logic                 o_tx_done;

    modport master (
        output i_tx_start,
        output i_tx_data,
        input  o_tx_busy,
        input  o_tx_done
    );

    modport slave (
        input  i_tx_start,
        input  i_tx_data,
        output o_tx_busy,
        output o_tx_done
    );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_gen
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_tick
);

    localparam int               CNT_W   = clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_r;

    // Bit-period counter, held at zero while cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (cnt_r == CNT_MAX) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign bit_tick = (cnt_r == CNT_MAX);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: LSB-first frame with optional even parity (UART_TX_PARITY_EN).
// A start seen while the last stop cycle ends chains the next frame with no gap.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEF_DATA_BITS,
    parameter int STOP_BITS    = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_tx_if.slave      tx_if,
    output logic          o_tx
);

    localparam int                IDX_W    = clog2(DATA_BITS);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

    uart_state_e          state_r, state_nxt;
    logic [DATA_BITS-1:0] shift_r;
    logic [IDX_W-1:0]     idx_r, idx_nxt;
    logic                 stop_r, stop_nxt;
    logic                 tx_r, tx_nxt;
    logic                 busy_r, busy_nxt;
    logic                 done_r, done_nxt;
    logic                 load_s, shift_s, baud_clr_s, bit_tick_s;
`ifdef UART_TX_PARITY_EN
    logic                 parity_r;
`endif

    uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (baud_clr_s),
        .bit_tick (bit_tick_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state, next-output and datapath control decode.
    always_comb begin
        state_nxt  = state_r;
        idx_nxt    = idx_r;
        stop_nxt   = stop_r;
        tx_nxt     = tx_r;
        busy_nxt   = busy_r;
        done_nxt   = 1'b0;
        load_s     = 1'b0;
        shift_s    = 1'b0;
        baud_clr_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                baud_clr_s = 1'b1;
                if (tx_if.i_tx_start) begin
                    load_s    = 1'b1;
                    state_nxt = ST_START;
                    tx_nxt    = 1'b0;
                    busy_nxt  = 1'b1;
                end else begin
                    tx_nxt    = 1'b1;
                    busy_nxt  = 1'b0;
                end
            end
            ST_START: begin
                if (bit_tick_s) begin
                    state_nxt = ST_DATA;
                    idx_nxt   = '0;
                    tx_nxt    = shift_r[0];
                end else begin
                    state_nxt = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_tick_s) begin
                    if (idx_r == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt = ST_PARITY;
                        tx_nxt    = parity_r;
`else
                        state_nxt = ST_STOP;
                        tx_nxt    = 1'b1;
                        stop_nxt  = 1'b0;
`endif
                    end else begin
                        // Output the next bit while the register shifts it into place.
                        idx_nxt = idx_r + IDX_W'(1);
                        shift_s = 1'b1;
                        tx_nxt  = shift_r[1];
                    end
                end else begin
                    state_nxt = ST_DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_tick_s) begin
                    state_nxt = ST_STOP;
                    tx_nxt    = 1'b1;
                    stop_nxt  = 1'b0;
                end else begin
                    state_nxt = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (bit_tick_s) begin
                    if (stop_r == STOP_LAST) begin
                        done_nxt = 1'b1;
                        if (tx_if.i_tx_start) begin
                            load_s    = 1'b1;
                            state_nxt = ST_START;
                            tx_nxt    = 1'b0;
                            busy_nxt  = 1'b1;
                        end else begin
                            state_nxt = ST_IDLE;
                            tx_nxt    = 1'b1;
                            busy_nxt  = 1'b0;
                        end
                    end else begin
                        stop_nxt = 1'b1;
                    end
                end else begin
                    state_nxt = ST_STOP;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                tx_nxt    = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // Payload shift register, counters and registered line/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r <= '0;
            idx_r   <= '0;
            stop_r  <= 1'b0;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            if (load_s) begin
                shift_r <= tx_if.i_tx_data;
            end else if (shift_s) begin
                shift_r <= {1'b0, shift_r[DATA_BITS-1:1]};
            end else begin
                shift_r <= shift_r;
            end
            idx_r  <= idx_nxt;
            stop_r <= stop_nxt;
            tx_r   <= tx_nxt;
            busy_r <= busy_nxt;
            done_r <= done_nxt;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity of the accepted payload, captured alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_r <= 1'b0;
        end else if (load_s) begin
            parity_r <= even_parity(9'(tx_if.i_tx_data));
        end else begin
            parity_r <= parity_r;
        end
    end
`endif

    assign o_tx            = tx_r;
    assign tx_if.o_tx_busy = busy_r;
    assign tx_if.o_tx_done = done_r;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected frames, a line monitor
// decodes o_tx and checks framing, timing and done pulses against the queue.
module tb_uart_tx;

    localparam int CPB = 4;
    localparam int DB  = 8;
    localparam int SB  = 1;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NBITS = 1 + DB + P + SB;
    localparam int FRAME = NBITS * CPB;

    typedef struct {
        logic [7:0] data;
        logic       par;
        bit         b2b;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic o_tx;

    uart_tx_if #(.DATA_BITS(DB)) tx_if ();

    uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .STOP_BITS(SB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tx_if (tx_if),
        .o_tx  (o_tx)
    );

    always #5 clk = ~clk;

    exp_t            exp_q[$];
    exp_t            e;
    int              tests = 0;
    int              fails = 0;
    int              k = -1;
    int              cyc = 0;
    int              last_done = -1000;
    int              stray_done = 0;
    int              stray_busy = 0;
    int              frames_seen = 0;
    logic [NBITS-1:0] cap;
    bit              glitch;
    bit              busy_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Line monitor: decode frames from o_tx and score them against the queue.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            k = -1;
        end else begin
            if (k == FRAME) begin
                check("done_pulse", tx_if.o_tx_done, 1);
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("start_bit", cap[0], 0);
                    check("data", cap[DB:1], e.data);
`ifdef UART_TX_PARITY_EN
                    check("parity_bit", cap[DB+1], e.par);
`endif
                    check("stop_bit", cap[NBITS-1], 1);
                    check("bit_stable", glitch, 0);
                    check("busy_in_frame", busy_err, 0);
                    if (e.b2b) begin
                        check("b2b_done_spacing", cyc - last_done, FRAME);
                    end
                end
                last_done = cyc;
                frames_seen++;
                k = -1;
            end else if (tx_if.o_tx_done) begin
                stray_done++;
            end
            if (k < 0) begin
                if (o_tx == 1'b0) begin
                    k        = 0;
                    glitch   = 1'b0;
                    busy_err = 1'b0;
                    cap      = '1;
                end else if (tx_if.o_tx_busy) begin
                    stray_busy++;
                end
            end
            if (k >= 0) begin
                if (k % CPB == 0) begin
                    cap[k/CPB] = o_tx;
                end else if (o_tx !== cap[k/CPB]) begin
                    glitch = 1'b1;
                end
                if (tx_if.o_tx_busy !== 1'b1) begin
                    busy_err = 1'b1;
                end
                k++;
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic par);
        exp_q.push_back('{data: d, par: par, b2b: 1'b0});
        tx_if.i_tx_start = 1'b1;
        tx_if.i_tx_data  = d;
        @(negedge clk);
        tx_if.i_tx_start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (tx_if.o_tx_busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("frame_timeout", tx_if.o_tx_busy, 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        tx_if.i_tx_start = 1'b0;
        tx_if.i_tx_data  = 8'h00;

        // 1. reset
        repeat (3) @(negedge clk);
        check("rst_tx", o_tx, 1);
        check("rst_busy", tx_if.o_tx_busy, 0);
        check("rst_done", tx_if.o_tx_done, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_tx", o_tx, 1);
        check("post_rst_busy", tx_if.o_tx_busy, 0);

        // 2. single frame 0x55, latency and busy/done timing
        send(8'h55, 1'b0);
        check("accept_tx_low", o_tx, 0);
        check("accept_busy", tx_if.o_tx_busy, 1);
        repeat (FRAME - 1) @(negedge clk);
        check("last_stop_busy", tx_if.o_tx_busy, 1);
        check("last_stop_done", tx_if.o_tx_done, 0);
        @(negedge clk);
        check("end_busy", tx_if.o_tx_busy, 0);
        check("end_done", tx_if.o_tx_done, 1);
        @(negedge clk);
        check("done_one_cycle", tx_if.o_tx_done, 0);
        wait_idle();

        // 3. back-to-back with start held high, data changed after acceptance
        exp_q.push_back('{data: 8'hA3, par: 1'b0, b2b: 1'b0});
        tx_if.i_tx_start = 1'b1;
        tx_if.i_tx_data  = 8'hA3;
        @(negedge clk);
        tx_if.i_tx_data  = 8'h0F;
        exp_q.push_back('{data: 8'h0F, par: 1'b0, b2b: 1'b1});
        repeat (FRAME) @(negedge clk);
        tx_if.i_tx_start = 1'b0;
        check("b2b_start_low", o_tx, 0);
        check("b2b_busy", tx_if.o_tx_busy, 1);
        wait_idle();

        // 4. start while busy is ignored
        send(8'h00, 1'b0);
        repeat (15) @(negedge clk);
        tx_if.i_tx_start = 1'b1;
        tx_if.i_tx_data  = 8'hFF;
        @(negedge clk);
        tx_if.i_tx_start = 1'b0;
        wait_idle();
        repeat (FRAME) @(negedge clk);
        check("busy_start_frames", frames_seen, 4);

        // 5. reset during data bit 3 (frame bit 4)
        tx_if.i_tx_start = 1'b1;
        tx_if.i_tx_data  = 8'h00;
        @(negedge clk);
        tx_if.i_tx_start = 1'b0;
        repeat (17) @(negedge clk);
        check("pre_reset_line", o_tx, 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_tx", o_tx, 1);
        check("async_rst_busy", tx_if.o_tx_busy, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (FRAME) @(negedge clk);
        check("no_done_after_abort", frames_seen, 4);
        send(8'hC6, 1'b0);
        wait_idle();

        // 6. parity cases
        send(8'h07, 1'b1);
        wait_idle();
        send(8'h03, 1'b0);
        wait_idle();

        check("stray_done", stray_done, 0);
        check("stray_busy", stray_busy, 0);
        check("queue_drained", exp_q.size(), 0);
        check("frames_total", frames_seen, 7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
